// File: rtl/cnc_pkg.sv
// rtl/cnc_pkg.sv - shared encodings, widths and host state type for the CNC host driver
package cnc_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 17;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;
  localparam logic [1:0] MODE_ILL = 2'd3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BADMODE = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_TRUNC   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    RESP
  } host_state_t;

endpackage

// File: rtl/cnc_host.sv
// rtl/cnc_host.sv - serialises one CNC operation and collects its two-word result
module cnc_host
  import cnc_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [IN_W-1:0]  req_a,
  input  logic [IN_W-1:0]  req_b,
  input  logic [IN_W-1:0]  req_c,
  input  logic [IN_W-1:0]  req_d,
  output logic             cnc_in_valid,
  output logic [1:0]       cnc_mode,
  output logic [IN_W-1:0]  cnc_in,
  input  logic             cnc_out_valid,
  input  logic [OUT_W-1:0] cnc_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_real,
  output logic [OUT_W-1:0] rsp_imag,
  output logic [1:0]       rsp_err
);

  host_state_t      r_state, w_state_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic [1:0]       r_mode;
  logic [IN_W-1:0]  r_b, r_c, r_d;
  logic             r_in_valid, w_in_valid_n;
  logic [1:0]       r_cnc_mode, w_cnc_mode_n;
  logic [IN_W-1:0]  r_cnc_in, w_cnc_in_n;
  logic             r_rsp_valid, w_rsp_valid_n;
  logic [OUT_W-1:0] r_rsp_real, w_rsp_real_n;
  logic [OUT_W-1:0] r_rsp_imag, w_rsp_imag_n;
  logic [1:0]       r_rsp_err, w_rsp_err_n;
  logic             w_accept;

  assign req_ready    = (r_state == IDLE);
  assign w_accept     = req_valid && (r_state == IDLE);
  assign cnc_in_valid = r_in_valid;
  assign cnc_mode     = r_cnc_mode;
  assign cnc_in       = r_cnc_in;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_real     = r_rsp_real;
  assign rsp_imag     = r_rsp_imag;
  assign rsp_err      = r_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_in_valid  <= 1'b0;
      r_cnc_mode  <= '0;
      r_cnc_in    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_real  <= '0;
      r_rsp_imag  <= '0;
      r_rsp_err   <= '0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_in_valid  <= w_in_valid_n;
      r_cnc_mode  <= w_cnc_mode_n;
      r_cnc_in    <= w_cnc_in_n;
      r_rsp_valid <= w_rsp_valid_n;
      r_rsp_real  <= w_rsp_real_n;
      r_rsp_imag  <= w_rsp_imag_n;
      r_rsp_err   <= w_rsp_err_n;
      // A goes straight onto the pins at acceptance, so only B..D need holding
      if (w_accept) begin
        r_mode <= req_mode;
        r_b    <= req_b;
        r_c    <= req_c;
        r_d    <= req_d;
      end
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cnt_n       = r_cnt;
    w_in_valid_n  = 1'b0;
    w_cnc_mode_n  = '0;
    w_cnc_in_n    = '0;
    w_rsp_valid_n = r_rsp_valid;
    w_rsp_real_n  = r_rsp_real;
    w_rsp_imag_n  = r_rsp_imag;
    w_rsp_err_n   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (req_mode == MODE_ILL) begin
            w_state_n     = RESP;
            w_rsp_valid_n = 1'b1;
            w_rsp_err_n   = ERR_BADMODE;
            w_rsp_real_n  = '0;
            w_rsp_imag_n  = '0;
          end else begin
            w_state_n    = SEND;
            w_cnt_n      = '0;
            w_in_valid_n = 1'b1;
            w_cnc_mode_n = req_mode;
            w_cnc_in_n   = req_a;
          end
        end
      end
      SEND: begin
        if (r_cnt == CW'(3)) begin
          w_state_n = WAIT;
          w_cnt_n   = '0;
        end else begin
          w_cnt_n      = r_cnt + CW'(1);
          w_in_valid_n = 1'b1;
          w_cnc_mode_n = r_mode;
          case (r_cnt[1:0])
            2'd0:    w_cnc_in_n = r_b;
            2'd1:    w_cnc_in_n = r_c;
            default: w_cnc_in_n = r_d;
          endcase
        end
      end
      WAIT: begin
        if (cnc_out_valid) begin
          w_rsp_real_n = cnc_out;
          w_state_n    = RECV;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state_n     = RESP;
          w_rsp_valid_n = 1'b1;
          w_rsp_err_n   = ERR_TIMEOUT;
          w_rsp_real_n  = '0;
          w_rsp_imag_n  = '0;
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      RECV: begin
        w_state_n     = RESP;
        w_rsp_valid_n = 1'b1;
        if (cnc_out_valid) begin
          w_rsp_imag_n = cnc_out;
          w_rsp_err_n  = ERR_OK;
        end else begin
          w_rsp_imag_n = '0;
          w_rsp_err_n  = ERR_TRUNC;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_n = 1'b0;
          w_state_n     = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnc_host.sv
// tb/tb_cnc_host.sv - directed self-checking bench for cnc_host with a behavioural CNC
module tb_cnc_host;
  import cnc_pkg::*;

  localparam int K_FULL = 0, K_SILENT = 1, K_SINGLE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_mode;
  logic [7:0]  req_a, req_b, req_c, req_d;
  logic        cnc_in_valid;
  logic [1:0]  cnc_mode;
  logic [7:0]  cnc_in;
  logic        cnc_out_valid;
  logic [16:0] cnc_out;
  logic        rsp_valid, rsp_ready;
  logic [16:0] rsp_real, rsp_imag;
  logic [1:0]  rsp_err;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, t_acc = 0, bad_idle_mode = 0;
  int cnc_kind = K_FULL;
  logic [7:0] sent_data[$];
  logic [1:0] sent_mode[$];
  int         sent_cyc[$];

  cnc_host dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .cnc_in_valid(cnc_in_valid), .cnc_mode(cnc_mode), .cnc_in(cnc_in),
    .cnc_out_valid(cnc_out_valid), .cnc_out(cnc_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_real(rsp_real), .rsp_imag(rsp_imag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && cnc_in_valid) begin
      sent_data.push_back(cnc_in);
      sent_mode.push_back(cnc_mode);
      sent_cyc.push_back(cyc);
    end
    if (!cnc_in_valid && cnc_mode != 2'd0) bad_idle_mode++;
  end

  // Behavioural CNC: 3-cycle add/sub, 5-cycle mul, optionally silent or single-word
  initial begin
    logic signed [7:0]  w[4];
    logic signed [16:0] re, im;
    logic [1:0]         md;
    int                 nw;
    cnc_out_valid = 1'b0;
    cnc_out       = '0;
    nw            = 0;
    forever begin
      @(negedge clk);
      if (rst) nw = 0;
      else if (cnc_in_valid) begin
        w[nw] = cnc_in;
        md    = cnc_mode;
        nw++;
        if (nw == 4) begin
          nw = 0;
          case (md)
            MODE_ADD: begin re = w[0] + w[2]; im = w[1] + w[3]; end
            MODE_SUB: begin re = w[0] - w[2]; im = w[1] - w[3]; end
            default:  begin re = w[0] * w[2] - w[1] * w[3]; im = w[0] * w[3] + w[1] * w[2]; end
          endcase
          if (cnc_kind != K_SILENT) begin
            repeat ((md == MODE_MUL) ? 5 : 3) @(posedge clk);
            #1 cnc_out_valid = 1'b1; cnc_out = re;
            if (cnc_kind == K_FULL) begin
              @(posedge clk);
              #1 cnc_out = im;
            end
            @(posedge clk);
            #1 cnc_out_valid = 1'b0; cnc_out = '0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [7:0] a, b, c, d, output int lat);
    sent_data.delete(); sent_mode.delete(); sent_cyc.delete();
    @(negedge clk);
    req_valid = 1'b1; req_mode = m; req_a = a; req_b = b; req_c = c; req_d = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    t_acc = cyc;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take_rsp(input string tag);
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_take: rsp_valid=%b req_ready=%b, required 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || cnc_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b cnc_in_valid=%b, required 1/0/0", req_ready, rsp_valid, cnc_in_valid);
    end
    n_tests++;
    if (cnc_mode !== 2'd0 || cnc_in !== 8'd0 || rsp_real !== 17'd0 || rsp_imag !== 17'd0 || rsp_err !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: mode=%0d in=%0h real=%0h imag=%0h err=%0d, required all 0", cnc_mode, cnc_in, rsp_real, rsp_imag, rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat;
    logic [7:0] exp_w[4];
    exp_w = '{8'd3, 8'hFE, 8'd5, 8'd7};
    cnc_kind = K_FULL;
    issue(MODE_ADD, 8'd3, 8'hFE, 8'd5, 8'd7, lat);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= sent_data.size()) begin
        n_fail++;
        $display("FAIL add_word%0d: missing, required %0h", i, exp_w[i]);
      end else if (sent_data[i] !== exp_w[i] || sent_cyc[i] !== t_acc + i || sent_mode[i] !== MODE_ADD) begin
        n_fail++;
        $display("FAIL add_word%0d: got %0h mode %0d at T+%0d, required %0h mode 0 at T+%0d",
                 i, sent_data[i], sent_mode[i], sent_cyc[i] - t_acc + 1, exp_w[i], i + 1);
      end
    end
    n_tests++;
    if (sent_data.size() != 4) begin
      n_fail++;
      $display("FAIL add_count: %0d words sent, required 4", sent_data.size());
    end
    n_tests++;
    if (lat != 9 || rsp_real !== 17'd8 || rsp_imag !== 17'd5 || rsp_err !== ERR_OK) begin
      n_fail++;
      $display("FAIL add_rsp: lat=%0d real=%0h imag=%0h err=%0d, required 9/8/5/0", lat, rsp_real, rsp_imag, rsp_err);
    end
    take_rsp("add");
  endtask

  task automatic test_sub;
    int lat;
    cnc_kind = K_FULL;
    issue(MODE_SUB, 8'h80, 8'h7F, 8'h7F, 8'h80, lat);
    n_tests++;
    if (lat != 9 || rsp_real !== 17'h1FF01 || rsp_imag !== 17'h000FF || rsp_err !== ERR_OK) begin
      n_fail++;
      $display("FAIL sub_rsp: lat=%0d real=%0h imag=%0h err=%0d, required 9/1ff01/ff/0", lat, rsp_real, rsp_imag, rsp_err);
    end
    take_rsp("sub");
  endtask

  task automatic test_mul;
    int lat;
    cnc_kind = K_FULL;
    issue(MODE_MUL, 8'h80, 8'h80, 8'h80, 8'h80, lat);
    n_tests++;
    if (sent_mode.size() != 4 || sent_mode[0] !== MODE_MUL || sent_mode[3] !== MODE_MUL) begin
      n_fail++;
      $display("FAIL mul_mode: %0d words, required 4 words with mode 2", sent_mode.size());
    end
    n_tests++;
    if (lat != 11 || rsp_real !== 17'd0 || rsp_imag !== 17'h08000 || rsp_err !== ERR_OK) begin
      n_fail++;
      $display("FAIL mul_rsp: lat=%0d real=%0h imag=%0h err=%0d, required 11/0/8000/0", lat, rsp_real, rsp_imag, rsp_err);
    end
    take_rsp("mul");
  endtask

  task automatic test_bad_mode;
    int lat;
    issue(MODE_ILL, 8'd1, 8'd0, 8'd0, 8'd0, lat);
    n_tests++;
    if (lat != 1 || rsp_err !== ERR_BADMODE || rsp_real !== 17'd0 || rsp_imag !== 17'd0) begin
      n_fail++;
      $display("FAIL badmode_rsp: lat=%0d err=%0d real=%0h imag=%0h, required 1/1/0/0", lat, rsp_err, rsp_real, rsp_imag);
    end
    take_rsp("badmode");
    n_tests++;
    if (sent_data.size() != 0) begin
      n_fail++;
      $display("FAIL badmode_traffic: %0d words sent, required 0", sent_data.size());
    end
  endtask

  task automatic test_timeout;
    int lat;
    cnc_kind = K_SILENT;
    issue(MODE_ADD, 8'd9, 8'd9, 8'd9, 8'd9, lat);
    n_tests++;
    if (lat != 21 || rsp_err !== ERR_TIMEOUT || rsp_real !== 17'd0 || rsp_imag !== 17'd0) begin
      n_fail++;
      $display("FAIL timeout_rsp: lat=%0d err=%0d real=%0h imag=%0h, required 21/2/0/0", lat, rsp_err, rsp_real, rsp_imag);
    end
    take_rsp("timeout");
  endtask

  task automatic test_trunc;
    int lat;
    cnc_kind = K_SINGLE;
    issue(MODE_ADD, 8'd3, 8'hFE, 8'd5, 8'd7, lat);
    n_tests++;
    if (lat != 9 || rsp_err !== ERR_TRUNC || rsp_real !== 17'd8 || rsp_imag !== 17'd0) begin
      n_fail++;
      $display("FAIL trunc_rsp: lat=%0d err=%0d real=%0h imag=%0h, required 9/3/8/0", lat, rsp_err, rsp_real, rsp_imag);
    end
    take_rsp("trunc");
  endtask

  task automatic test_hold;
    int lat;
    cnc_kind = K_FULL;
    issue(MODE_ADD, 8'd3, 8'hFE, 8'd5, 8'd7, lat);
    req_mode = MODE_SUB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) req_valid = 1'b1;
      n_tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_real !== 17'd8 || rsp_imag !== 17'd5 || rsp_err !== ERR_OK) begin
        n_fail++;
        $display("FAIL hold_cyc%0d: valid=%b ready=%b real=%0h imag=%0h err=%0d, required 1/0/8/5/0",
                 i, rsp_valid, req_ready, rsp_real, rsp_imag, rsp_err);
      end
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0; req_valid = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_take: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || cnc_in_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_noaccept: req_ready=%b cnc_in_valid=%b, required 1/0", req_ready, cnc_in_valid);
    end
  endtask

  task automatic test_reset_mid;
    cnc_kind = K_FULL;
    @(negedge clk);
    req_valid = 1'b1; req_mode = MODE_MUL; req_a = 8'd1; req_b = 8'd2; req_c = 8'd3; req_d = 8'd4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_tests++;
    if (cnc_in_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid: cnc_in_valid=%b req_ready=%b rsp_valid=%b, required 0/1/0", cnc_in_valid, req_ready, rsp_valid);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (cnc_in_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: cnc_in_valid=%b rsp_valid=%b, required 0/0", cnc_in_valid, rsp_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_mode = '0;
    req_a = '0; req_b = '0; req_c = '0; req_d = '0; rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_bad_mode();
    test_timeout();
    test_trunc();
    test_hold();
    test_reset_mid();
    test_add();
    n_tests++;
    if (bad_idle_mode != 0) begin
      n_fail++;
      $display("FAIL idle_mode: cnc_mode nonzero while idle %0d times, required 0", bad_idle_mode);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
